// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: scans one digit per scan_tick with an anode-off guard before each digit.
// Latency: seg/an registered; seg updates on the tick edge, anode enables GUARD+1 clocks after the tick.
// Backpressure: none; loads are always accepted into a single pending buffer (latest wins) and committed at frame wrap.
module seg7_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int GUARD    = 4,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_tick,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_sync
);

  localparam int              IW         = $clog2(DIGITS);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [7:0]      GUARD_INIT = 8'(GUARD);
  localparam logic [6:0]      SEG_BLANK  = 7'h7F;

  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] pending;
  logic                pending_valid;
  logic [IW-1:0]       idx;
  logic [7:0]          guard_cnt;
  logic                armed;

  logic                wrap;
  logic                commit;
  logic [IW-1:0]       idx_next;
  logic [4*DIGITS-1:0] disp_next;
  logic [3:0]          new_nib;
  logic                new_blank;
  logic                zero_run;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   an_active;

  // Active-low hex decode; anything above 9 renders as a lone dash (segment g).
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // Tick bookkeeping: next digit index, and whether this tick closes the frame and commits new data.
  always_comb begin
    wrap      = scan_tick && (idx == LAST_IDX);
    idx_next  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    commit    = wrap && (load || pending_valid);
    // A load coinciding with the wrap bypasses the pending buffer so the freshest value is shown.
    disp_next = !commit ? disp : (load ? bcd_in : pending);
    an_active = ~(DIGITS'(1) << idx);
  end

  // Select the digit about to be shown and decide leading-zero blanking from the post-commit display word.
  always_comb begin
    zero_run  = 1'b1;
    new_nib   = 4'd0;
    new_blank = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_next[4*k +: 4] == 4'd0);
      if (idx_next == IW'(k)) begin
        new_nib   = disp_next[4*k +: 4];
        new_blank = LZ_BLANK && (k != 0) && zero_run;
      end
    end
    seg_next = new_blank ? SEG_BLANK : decode(new_nib);
  end

  // Scan state, guard countdown, double-buffered data and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      an            <= '1;
      seg           <= SEG_BLANK;
      frame_sync    <= 1'b0;
      disp          <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      idx           <= LAST_IDX;
      guard_cnt     <= 8'd0;
      armed         <= 1'b0;
    end else begin
      frame_sync <= commit;
      disp       <= disp_next;

      if (scan_tick) begin
        idx       <= idx_next;
        an        <= '1;
        guard_cnt <= GUARD_INIT;
        seg       <= seg_next;
        armed     <= 1'b1;
      end else if (guard_cnt != 8'd0) begin
        guard_cnt <= guard_cnt - 8'd1;
        an        <= '1;
      end else if (armed) begin
        an <= an_active;
      end

      if (commit) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= bcd_in;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (leading-zero blanking on and off) driven from shared stimulus.
// Expected seg/an/frame_sync per tick are queued when the tick is driven and compared when it appears.
// No backpressure on the DUT; all waits are fixed cycle counts.
module tb_seg7_scan_mux;

  logic        clk;
  logic        rst;
  logic        scan_tick;
  logic [15:0] bcd_in;
  logic        load;
  logic [3:0]  an,   an_n;
  logic [6:0]  seg,  seg_n;
  logic        frame_sync, frame_sync_n;

  typedef struct packed {
    logic [6:0] seg;
    logic [6:0] seg_n;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  seg7_scan_mux #(.DIGITS(4), .GUARD(4), .LZ_BLANK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .bcd_in(bcd_in), .load(load),
    .an(an), .seg(seg), .frame_sync(frame_sync)
  );

  seg7_scan_mux #(.DIGITS(4), .GUARD(4), .LZ_BLANK(1'b0)) u_dut_nolz (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .bcd_in(bcd_in), .load(load),
    .an(an_n), .seg(seg_n), .frame_sync(frame_sync_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load   = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; scan_tick = 1'b0; load = 1'b0; bcd_in = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (an !== 4'hF) begin miscompares++; $display("FAIL reset_an cyc %0d: got %h want F", c, an); end
      vectors++;
      if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg cyc %0d: got %h want 7F", c, seg); end
      vectors++;
      if (frame_sync !== 1'b0) begin miscompares++; $display("FAIL reset_fs cyc %0d: got %b want 0", c, frame_sync); end
    end
  endtask

  // One full frame of four ticks starting from idx=3; segs packed {d3,d2,d1,d0}.
  task automatic test_frame(input string name, input logic [27:0] segs, input logic [27:0] segs_n,
                            input logic fs0, input int mid_slot, input logic [15:0] mid_val,
                            input logic wrap_load, input logic [15:0] wrap_val);
    exp_t e;
    exp_t p;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      scan_tick = 1'b1;
      load      = (s == 0) && wrap_load;
      if ((s == 0) && wrap_load) bcd_in = wrap_val;
      e.seg   = segs[7*s +: 7];
      e.seg_n = segs_n[7*s +: 7];
      e.an    = ~(4'b0001 << s);
      e.fs    = (s == 0) ? fs0 : 1'b0;
      sb.push_back(e);
      @(negedge clk);
      scan_tick = 1'b0;
      load      = 1'b0;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL %s_sb slot %0d: got empty queue want entry", name, s);
        p = e;
      end else begin
        p = sb.pop_front();
      end
      vectors++;
      if (seg !== p.seg) begin miscompares++; $display("FAIL %s_seg slot %0d: got %h want %h", name, s, seg, p.seg); end
      vectors++;
      if (seg_n !== p.seg_n) begin miscompares++; $display("FAIL %s_seg_nolz slot %0d: got %h want %h", name, s, seg_n, p.seg_n); end
      vectors++;
      if (frame_sync !== p.fs || frame_sync_n !== p.fs) begin
        miscompares++; $display("FAIL %s_fs slot %0d: got %b/%b want %b", name, s, frame_sync, frame_sync_n, p.fs);
      end
      vectors++;
      if (an !== 4'hF) begin miscompares++; $display("FAIL %s_an_tick slot %0d: got %h want F", name, s, an); end
      for (int g = 1; g <= 4; g++) begin
        @(negedge clk);
        vectors++;
        if (an !== 4'hF || frame_sync !== 1'b0) begin
          miscompares++; $display("FAIL %s_guard slot %0d cyc %0d: got an=%h fs=%b want an=F fs=0", name, s, g, an, frame_sync);
        end
      end
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        vectors++;
        if (an !== p.an || an_n !== p.an) begin
          miscompares++; $display("FAIL %s_an slot %0d cyc %0d: got %b/%b want %b", name, s, j, an, an_n, p.an);
        end
      end
      if (s == mid_slot) begin
        load   = 1'b1;
        bcd_in = mid_val;
      end
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_scan;
    do_load(16'h1234);
    test_frame("scan", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_lz_blank;
    do_load(16'h0042);
    test_frame("lz42", {7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h40, 7'h40, 7'h19, 7'h24}, 1'b1, -1, 16'h0, 1'b0, 16'h0);
    do_load(16'h0000);
    test_frame("lz00", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_pending;
    do_load(16'h1234);
    test_frame("pend_a", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 1, 16'h5678, 1'b0, 16'h0);
    test_frame("pend_b", {7'h12, 7'h02, 7'h78, 7'h00}, {7'h12, 7'h02, 7'h78, 7'h00}, 1'b1, -1, 16'h0, 1'b0, 16'h0);
    test_frame("bypass", {7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b1, -1, 16'h0, 1'b1, 16'h9999);
    test_frame("nopend", {7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_invalid;
    do_load(16'h00A1);
    test_frame("dash", {7'h7F, 7'h7F, 7'h3F, 7'h79}, {7'h40, 7'h40, 7'h3F, 7'h79}, 1'b1, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_back_to_back;
    logic [27:0] segs_t;
    logic [27:0] segs_nt;
    exp_t        e;
    exp_t        p;
    segs_t  = {7'h7F, 7'h7F, 7'h3F, 7'h79};
    segs_nt = {7'h40, 7'h40, 7'h3F, 7'h79};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      scan_tick = 1'b1;
      load      = (s == 3);
      bcd_in    = 16'h5555;
      e.seg   = segs_t[7*s +: 7];
      e.seg_n = segs_nt[7*s +: 7];
      e.an    = 4'hF;
      e.fs    = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      scan_tick = 1'b0;
      load      = 1'b0;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL b2b_sb slot %0d: got empty queue want entry", s);
        p = e;
      end else begin
        p = sb.pop_front();
      end
      vectors++;
      if (seg !== p.seg || seg_n !== p.seg_n) begin
        miscompares++; $display("FAIL b2b_seg slot %0d: got %h/%h want %h/%h", s, seg, seg_n, p.seg, p.seg_n);
      end
      vectors++;
      if (an !== p.an || frame_sync !== p.fs) begin
        miscompares++; $display("FAIL b2b_an slot %0d: got an=%h fs=%b want an=%h fs=%b", s, an, frame_sync, p.an, p.fs);
      end
      @(negedge clk);
      vectors++;
      if (an !== 4'hF) begin miscompares++; $display("FAIL b2b_an_gap slot %0d: got %h want F", s, an); end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (an !== 4'hF || an_n !== 4'hF) begin miscompares++; $display("FAIL rst_mid_an: got %h/%h want F", an, an_n); end
    vectors++;
    if (seg !== 7'h7F || seg_n !== 7'h7F) begin miscompares++; $display("FAIL rst_mid_seg: got %h/%h want 7F", seg, seg_n); end
    vectors++;
    if (frame_sync !== 1'b0) begin miscompares++; $display("FAIL rst_mid_fs: got %b want 0", frame_sync); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (an !== 4'hF || frame_sync !== 1'b0) begin
        miscompares++; $display("FAIL rst_idle cyc %0d: got an=%h fs=%b want an=F fs=0", c, an, frame_sync);
      end
    end
    test_frame("post_rst", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, -1, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_scan();
    test_lz_blank();
    test_pending();
    test_invalid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
